// File: rtl/serial_bit_streamer.sv
// Parallel-to-serial output stage: valid/ready word input, one bit per clock with frame markers.
// Optional trailing even-parity bit when SER_PARITY_EN is defined.
module serial_bit_streamer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_last_q, ser_last_d;
    logic             done_q, done_d;
    logic             accept;
    logic             frame_end;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // The shift register always holds the not-yet-sent bits aligned to the send end.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

`ifdef SER_PARITY_EN
    assign frame_end = (state_q == PARITY);
`else
    assign frame_end = (state_q == SHIFT) && (cnt_q == LAST_DATA);
`endif

    // Ready during the final frame bit lets the next word follow with no gap.
    assign in_ready  = !rst && ((state_q == IDLE) || frame_end);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        done_d      = frame_end;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif
        if (accept) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            shreg_d     = shift_word(in_data);
            ser_out_d   = head_bit(in_data);
            ser_valid_d = 1'b1;
            ser_first_d = 1'b1;
`ifdef SER_PARITY_EN
            par_d       = ^in_data;
`endif
        end else if ((state_q == SHIFT) && (cnt_q != LAST_DATA)) begin
            cnt_d       = cnt_q + CNT_W'(1);
            shreg_d     = shift_word(shreg_q);
            ser_out_d   = head_bit(shreg_q);
`ifdef SER_PARITY_EN
            ser_last_d  = 1'b0;
`else
            ser_last_d  = (cnt_d == LAST_DATA);
`endif
        end
`ifdef SER_PARITY_EN
        else if (state_q == SHIFT) begin
            state_d     = PARITY;
            cnt_d       = CNT_W'(WIDTH);
            ser_out_d   = par_q;
            ser_last_d  = 1'b1;
        end
`endif
        else if (frame_end) begin
            state_d     = IDLE;
            cnt_d       = '0;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            done_q      <= done_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_serial_bit_streamer.sv
// Bench for serial_bit_streamer: MSB-first and LSB-first instances share one stimulus and one frame-queue model.
module tb_serial_bit_streamer;
    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
    localparam logic [15:0] L1_M = 16'b1_1001_0100;
    localparam logic [15:0] L1_L = 16'b0_1010_0110;
    localparam logic [15:0] L81  = 16'b1_0000_0010;
`else
    localparam int FL = W;
    localparam logic [15:0] L1_M = 16'b1100_1010;
    localparam logic [15:0] L1_L = 16'b0101_0011;
    localparam logic [15:0] L81  = 16'b1000_0001;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [W-1:0] in_data;
    logic rdy_m, out_m, val_m, fst_m, lst_m, busy_m, done_m;
    logic rdy_l, out_l, val_l, fst_l, lst_l, busy_l, done_l;

    always #5 clk = ~clk;

    serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
        .ser_out(out_m), .ser_valid(val_m), .ser_first(fst_m), .ser_last(lst_m),
        .busy(busy_m), .done(done_m));

    serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
        .ser_out(out_l), .ser_valid(val_l), .ser_first(fst_l), .ser_last(lst_l),
        .busy(busy_l), .done(done_l));

    // Model: each accepted word becomes a queue of frame bits; one item is shown per cycle.
    typedef struct packed {logic v; logic bm; logic bl; logic first; logic last;} item_t;
    item_t pend[$];
    item_t cur = '0;
    logic  exp_done = 1'b0;
    logic  was_rst = 1'b1;
    logic  last_accept = 1'b0;
    logic  started = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic logic exp_ready();
        return !rst && (pend.size() == 0);
    endfunction

    always @(posedge clk) begin
        logic acc;
        acc = in_valid && exp_ready();
        last_accept = acc;
        started = 1'b1;
        if (rst) begin
            pend.delete();
            cur = '0;
            exp_done = 1'b0;
            was_rst = 1'b1;
        end else begin
            was_rst = 1'b0;
            exp_done = cur.last;
            if (acc) begin
                for (int k = 0; k < FL; k++) begin
                    item_t it;
                    if (k < W) begin
                        it.bm = in_data[W-1-k];
                        it.bl = in_data[k];
                    end else begin
                        it.bm = ^in_data;
                        it.bl = ^in_data;
                    end
                    it.v = 1'b1;
                    it.first = (k == 0);
                    it.last = (k == FL - 1);
                    pend.push_back(it);
                end
            end
            if (pend.size() > 0) cur = pend.pop_front();
            else cur = '0;
        end
    end

    task automatic check_dut(input string nm, input logic r, input logic v, input logic o,
                             input logic f, input logic l, input logic b, input logic d,
                             input logic eb);
        logic [6:0] act, expv, mask;
        act  = {r, v, o, f, l, b, d};
        expv = {exp_ready(), cur.v, cur.v ? eb : 1'b0, cur.first, cur.last, cur.v, exp_done};
        mask = 7'h7F;
        if (!cur.v && !was_rst) mask[4] = 1'b0;
        checks++;
        if ((act & mask) !== (expv & mask)) begin
            errors++;
            $display("FAIL %s t=%0t rdy,val,out,first,last,busy,done got=%b required=%b",
                     nm, $time, act, expv);
        end
    endtask

    // Requests from the stimulus for literal/frame-level checks, executed by the monitor.
    int          lit_req = 0;
    int          lit_done = 0;
    int          lit_kind = 0;
    string       lit_name = "";
    logic [15:0] lit_m = '0, lit_l = '0;
    int          lit_run = 0;
    logic [15:0] cap_m = '0, cap_l = '0, frame_m = '0, frame_l = '0;
    int          run = 0, max_run = 0;

    always @(negedge clk) begin
        if (started) begin
            check_dut("msb_first_outputs", rdy_m, val_m, out_m, fst_m, lst_m, busy_m, done_m, cur.bm);
            check_dut("lsb_first_outputs", rdy_l, val_l, out_l, fst_l, lst_l, busy_l, done_l, cur.bl);
            if (val_m) begin
                cap_m = fst_m ? {15'b0, out_m} : {cap_m[14:0], out_m};
                if (lst_m) frame_m = cap_m;
                run++;
            end else begin
                run = 0;
            end
            if (val_l) begin
                cap_l = fst_l ? {15'b0, out_l} : {cap_l[14:0], out_l};
                if (lst_l) frame_l = cap_l;
            end
            if (run > max_run) max_run = run;
            if (lit_req != lit_done) begin
                if (lit_kind == 0) begin
                    checks++;
                    if (frame_m !== lit_m) begin
                        errors++;
                        $display("FAIL %s_msb frame got=%b required=%b", lit_name, frame_m, lit_m);
                    end
                    checks++;
                    if (frame_l !== lit_l) begin
                        errors++;
                        $display("FAIL %s_lsb frame got=%b required=%b", lit_name, frame_l, lit_l);
                    end
                end else if (lit_kind == 1) begin
                    checks++;
                    if (max_run != lit_run) begin
                        errors++;
                        $display("FAIL %s valid run got=%0d required=%0d", lit_name, max_run, lit_run);
                    end
                end
                frame_m = '0;
                frame_l = '0;
                max_run = 0;
                lit_done = lit_req;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input int kind, input string nm, input logic [15:0] m,
                       input logic [15:0] l, input int r);
        lit_kind = kind;
        lit_name = nm;
        lit_m = m;
        lit_l = l;
        lit_run = r;
        lit_req++;
        step();
    endtask

    task automatic send(input logic [W-1:0] w, input bit hold);
        in_valid = 1'b1;
        in_data = w;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (last_accept) begin
                #1;
                if (!hold) in_valid = 1'b0;
                return;
            end
        end
        $display("FAIL send_timeout word=%h not accepted within 40 cycles", w);
        $fatal(1, "send timeout");
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) step();

        req(2, "clear", '0, '0, 0);
        send(8'b11001010, 1'b0);
        repeat (FL + 2) step();
        req(0, "word_ca", L1_M, L1_L, 0);

        send(8'hA5, 1'b1);
        send(8'h3C, 1'b0);
        repeat (2 * FL + 4) step();
        req(1, "back_to_back", '0, '0, 2 * FL);

        send(8'hFF, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        send(8'h81, 1'b0);
        repeat (FL + 2) step();
        req(0, "after_abort_81", L81, L81, 0);

`ifdef SER_PARITY_EN
        send(8'h07, 1'b0);
        repeat (FL + 2) step();
        req(0, "parity_07", 16'b0_0000_1111, 16'b1_1100_0001, 0);
`endif

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(9) < 6);
            in_data = W'($urandom);
            rst = ($urandom_range(59) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (FL + 4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_bit_streamer.md
Name: serial_bit_streamer

Overview:
- Parallel-to-serial output stage that consumes WIDTH-bit words, typically the bit-reversed byte produced by the preceding reversal stage.
- Emits each word one bit per clock, in a selectable bit order, with frame markers.
- Uses a valid/ready handshake on the input side so back-to-back words stream with no idle gap.
- Sits between the word-level datapath and a bit-serial sink: a shift-out link or bench monitor.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- MSB_FIRST, 1, 1 = send in_data[WIDTH-1] first; 0 = send in_data[0] first (equivalent to bit-reversing the word).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to serialise, sampled on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_first  output  1  first bit of frame.
- ser_last  output  1  final bit of frame.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse, cycle after the final bit.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. Polarity and synchronicity are fixed.
- Reset (rst high at a clk edge):
  - state ← IDLE; shift register, bit counter, ser_out, ser_valid, ser_first, ser_last, busy and done all ← 0.
  - in_ready is 0 while rst is high; it is 1 from the first cycle after rst deasserts.
- Accept: a word is taken at edge T when in_valid && in_ready.
  - in_data is latched into the shift register.
  - The first bit appears on ser_out with ser_valid=1 and ser_first=1 in cycle T+1 (registered outputs, latency 1).
- States:
  - IDLE: in_ready=1. On accept → SHIFT, counter=0.
  - SHIFT: one bit per cycle; counter increments; ser_valid=1 every cycle.
    - ser_first=1 when counter==0.
    - ser_last=1 when counter==WIDTH-1.
    - After the last bit: → SHIFT if a new word is accepted in that cycle, else → IDLE.
  - PARITY: exists only with the optional feature.
- Bit order:
  - MSB_FIRST=1: bit k of the frame = word[WIDTH-1-k].
  - MSB_FIRST=0: bit k = word[k].
- in_ready rule: 1 in IDLE; also 1 during the cycle the final frame bit is driven (counter==WIDTH-1, feature off). This gives gapless streaming. 0 otherwise in SHIFT.
- in_valid while in_ready=0: ignored, not latched. Upstream holds the data.
- busy = (state != IDLE).
- done: pulses 1 in the cycle after ser_last. It also pulses when a back-to-back word has already started; done and ser_first of the next frame may coincide.
- Counter: $clog2(WIDTH+1) bits; never exceeds WIDTH-1 (WIDTH with feature); no wrap.
- in_data changes after accept: no effect on the frame in flight.
- Reset mid-frame: frame aborted immediately; next cycle outputs are at reset values. No partial ser_last and no done pulse.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, state PARITY emits one extra bit: even parity (XOR of all WIDTH bits of the latched word), with ser_valid=1.
  - ser_last moves from the last data bit to the parity bit.
  - in_ready back-to-back window moves to the PARITY cycle.
  - Frame length is WIDTH+1.
- Undefined: no PARITY state; frame length is WIDTH; behaviour exactly as above.

Test Plan:
- Reset, then idle: hold rst=1 for 3 cycles with in_valid=1 → in_ready=0 and all outputs 0; after release, in_ready=1, busy=0.
- MSB_FIRST=1, accept 8'b11001010 at T → ser_out = 1,1,0,0,1,0,1,0 over T+1..T+8; ser_first only at T+1; ser_last only at T+8; done at T+9; busy falls at T+9.
- MSB_FIRST=0, accept 8'b11001010 → ser_out = 0,1,0,1,0,0,1,1 (matches reversed word 8'b01010011 sent MSB-first).
- Back-to-back: in_valid held with 8'hA5, then 8'h3C → 16 consecutive ser_valid cycles with no gap; in_ready high only at T and T+8; second ser_first coincides with done.
- Reset mid-frame: assert rst after 3 bits of 8'hFF → next cycle ser_valid=0, busy=0, no done; a fresh 8'h81 then streams 1,0,0,0,0,0,0,1.
- SER_PARITY_EN defined:
  - 8'b11001010 → 9 bits, 9th = 0, ser_last on bit 9.
  - 8'h07 → 9th bit = 1.
  - Back-to-back frames span 18 contiguous valid cycles.
